// File: rtl/digit_split.sv
// Splits a signed 32-bit value into decimal digits, MSB first (sign code first if negative), then a done beat.
// One SCAN action per cycle (d+1 cycles per digit); stalls with the pending beat held while __valid && !__ready.
module digit_split #(
  parameter logic [31:0] SIGN_CODE = 32'd10
) (
  input  logic               __clock,
  input  logic               __reset,
  input  logic signed [31:0] n,
  input  logic               __start,
  input  logic               __ready,
  output logic               __valid,
  output logic               __done,
  output logic signed [31:0] __output_0
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  digit_q, digit_d;
  logic        leading_q, leading_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [31:0] out_q, out_d;
  logic [31:0] pow_cur;

  always_comb begin
    case (idx_q)
      4'd9:    pow_cur = 32'd1000000000;
      4'd8:    pow_cur = 32'd100000000;
      4'd7:    pow_cur = 32'd10000000;
      4'd6:    pow_cur = 32'd1000000;
      4'd5:    pow_cur = 32'd100000;
      4'd4:    pow_cur = 32'd10000;
      4'd3:    pow_cur = 32'd1000;
      4'd2:    pow_cur = 32'd100;
      4'd1:    pow_cur = 32'd10;
      default: pow_cur = 32'd1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    idx_d     = idx_q;
    digit_d   = digit_q;
    leading_d = leading_q;
    valid_d   = valid_q;
    done_d    = done_q;
    out_d     = out_q;

    if (__ready) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    if (__start) begin
      state_d   = SCAN;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      // Two's complement negate in 32 bits: -2^31 maps to 2^31 as unsigned.
      mag_d     = n[31] ? (~n + 32'd1) : n;
      idx_d     = 4'd9;
      digit_d   = 4'd0;
      leading_d = 1'b1;
      if (n[31]) begin
        out_d   = SIGN_CODE;
        valid_d = 1'b1;
      end
    end else if (__ready || !valid_q) begin
      case (state_q)
        SCAN: begin
          if (mag_q >= pow_cur) begin
            mag_d   = mag_q - pow_cur;
            digit_d = digit_q + 4'd1;
          end else if (leading_q && digit_q == 4'd0 && idx_q != 4'd0) begin
            idx_d = idx_q - 4'd1;
          end else begin
            out_d     = {28'd0, digit_q};
            valid_d   = 1'b1;
            leading_d = 1'b0;
            digit_d   = 4'd0;
            if (idx_q == 4'd0) state_d = DONE;
            else               idx_d   = idx_q - 4'd1;
          end
        end
        DONE: begin
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // __start wins over __reset, so reset only applies when no start is present.
  always_ff @(posedge __clock) begin
    if (__reset && !__start) begin
      state_q   <= IDLE;
      mag_q     <= 32'd0;
      idx_q     <= 4'd0;
      digit_q   <= 4'd0;
      leading_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      leading_q <= leading_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      out_q     <= out_d;
    end
  end

  assign __valid    = valid_q;
  assign __done     = done_q;
  assign __output_0 = out_q;

endmodule

// File: tb/tb_digit_split.sv
// Randomized bench for digit_split: a decimal-arithmetic model plus literal test-plan sequences.
module tb_digit_split;

  logic               clk;
  logic               rst;
  logic signed [31:0] n;
  logic               start;
  logic               ready;
  logic               valid;
  logic               done;
  logic signed [31:0] dout;

  digit_split #(.SIGN_CODE(32'd10)) dut (
    .__clock   (clk),
    .__reset   (rst),
    .n         (n),
    .__start   (start),
    .__ready   (ready),
    .__valid   (valid),
    .__done    (done),
    .__output_0(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int mdl_q[$];
  int lit_q[$];
  int rx_q[$];
  bit got_done = 1'b0;
  int beats = 0;
  int rmode = 0;

  bit          stable_pend = 1'b0;
  logic [31:0] held_out;
  logic        held_done;

  function automatic void model(input logic signed [31:0] v);
    longint m;
    int t[$];
    mdl_q.delete();
    m = v;
    if (m < 0) begin
      mdl_q.push_back(10);
      m = -m;
    end
    if (m == 0) mdl_q.push_back(0);
    while (m > 0) begin
      t.push_front(int'(m % 10));
      m = m / 10;
    end
    foreach (t[i]) mdl_q.push_back(t[i]);
  endfunction

  function automatic int seg(input int d);
    case (d)
      0: return 63;   1: return 6;    2: return 91;  3: return 79;
      4: return 102;  5: return 109;  6: return 125; 7: return 7;
      8: return 127;  9: return 111;  default: return 0;
    endcase
  endfunction

  // Ready driver
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b0;
      endcase
    end
  end

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!start && !rst) begin
      if (stable_pend) begin
        checks++;
        if (valid !== 1'b1 || dout !== held_out || done !== held_done) begin
          errors++;
          $display("FAIL stall_hold got valid=%0b out=%0d done=%0b want valid=1 out=%0d done=%0b",
                   valid, dout, done, held_out, held_done);
        end
      end
      stable_pend = valid && !ready;
      held_out    = dout;
      held_done   = done;
      if (done && !valid) begin
        checks++;
        errors++;
        $display("FAIL done_without_valid got done=1 valid=0 want valid=1");
      end
      if (valid && ready) begin
        if (done) begin
          checks++;
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_early got remaining=%0d want remaining=0", exp_q.size());
          end
          got_done = 1'b1;
        end else begin
          checks++;
          beats++;
          rx_q.push_back(int'(dout));
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat got=%0d want none", dout);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(dout) != e) begin
              errors++;
              $display("FAIL digit got=%0d want=%0d", dout, e);
            end
          end
        end
      end
    end else begin
      stable_pend = 1'b0;
    end
  end

  task automatic go(input logic signed [31:0] v, input int mode, input int stall, input bit use_lit);
    bit ok;
    model(v);
    if (use_lit) begin
      ok = (mdl_q.size() == lit_q.size());
      if (ok) foreach (lit_q[i]) if (mdl_q[i] != lit_q[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL model_pin n=%0d got_len=%0d want_len=%0d", v, mdl_q.size(), lit_q.size());
      end
    end
    rmode = (stall > 0) ? 2 : mode;
    @(posedge clk); #1;
    n = v;
    start = 1'b1;
    if (use_lit) exp_q = lit_q;
    else         exp_q = mdl_q;
    got_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (stall) @(posedge clk);
    rmode = mode;
    for (int c = 0; c < 3000 && !got_done; c++) @(posedge clk);
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL timeout n=%0d got done=0 want done=1", v);
    end
  endtask

  initial begin
    int fibv[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
    int fib_dig[9] = '{0, 1, 1, 2, 3, 5, 8, 1, 3};
    int fib_seg[9] = '{63, 6, 6, 91, 79, 109, 127, 6, 79};
    logic signed [31:0] rv;

    rst = 1'b1; start = 1'b0; n = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || done !== 1'b0 || dout !== 32'sd0) begin
      errors++;
      $display("FAIL reset_state got valid=%0b done=%0b out=%0d want 0 0 0", valid, done, dout);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    lit_q = '{3, 0, 5};                          go(305, 0, 0, 1);
    lit_q = '{0};                                go(0, 0, 0, 1);
    lit_q = '{9};                                go(9, 0, 0, 1);
    lit_q = '{10, 4, 2};                         go(-42, 0, 0, 1);
    lit_q = '{10, 2, 1, 4, 7, 4, 8, 3, 6, 4, 8}; go(32'sh80000000, 0, 0, 1);
    lit_q = '{2, 1, 4, 7, 4, 8, 3, 6, 4, 7};     go(32'sh7fffffff, 1, 0, 1);
    lit_q = '{10, 4, 2};                         go(-42, 0, 25, 1);
    lit_q = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};     go(1000000000, 1, 0, 1);

    // Restart with a new start after the first beat of 123.
    rmode = 0;
    @(posedge clk); #1;
    n = 123; start = 1'b1; exp_q = '{1, 2, 3}; got_done = 1'b0; beats = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && beats == 0; c++) begin
      @(posedge clk); #1;
    end
    n = 7; start = 1'b1; exp_q = '{7}; got_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 500 && !got_done; c++) @(posedge clk);
    checks++;
    if (!got_done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_start got done=%0b left=%0d want done=1 left=0", got_done, exp_q.size());
    end

    // Reset after the first beat of 123: no further beats.
    @(posedge clk); #1;
    n = 123; start = 1'b1; exp_q = '{1, 2, 3}; got_done = 1'b0; beats = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && beats == 0; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || dout !== 32'sd0) begin
        errors++;
        $display("FAIL abort_reset got valid=%0b out=%0d want valid=0 out=0", valid, dout);
      end
    end

    // Fib chain into seven_seg.
    rx_q.delete();
    foreach (fibv[i]) go(fibv[i], 1, 0, 0);
    checks++;
    if (rx_q.size() != 9) begin
      errors++;
      $display("FAIL chain_len got=%0d want=9", rx_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx_q[i] != fib_dig[i] || seg(rx_q[i]) != fib_seg[i]) begin
          errors++;
          $display("FAIL chain_%0d got digit=%0d code=%0d want digit=%0d code=%0d",
                   i, rx_q[i], seg(rx_q[i]), fib_dig[i], fib_seg[i]);
        end
      end
    end

    for (int k = 0; k < 30; k++) begin
      case (k % 3)
        0:       rv = $signed($urandom);
        1:       rv = -$signed(32'($urandom_range(0, 99999)));
        default: rv = $signed(32'($urandom_range(0, 999)));
      endcase
      go(rv, (k % 2 == 0) ? 1 : 0, (k % 5 == 0) ? 7 : 0, 0);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
